// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS16 generator/checker pair: state encoding,
// feedback taps and the single-step function both sides must agree on.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Taps 15,13,12,10 give x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] POLY_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] x);
        return {x[14:0], ^(x & POLY_TAPS)};
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] x);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating accumulator: clears synchronously, otherwise adds inc_i when
// en_i is high and clamps at the all-ones value instead of wrapping.
module sat_cnt #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_o
);

    // One spare bit above the wider operand so the overflow is visible.
    localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SW-1:0] MAX = SW'({W{1'b1}});

    logic [W-1:0]  cnt_q;
    logic [W-1:0]  cnt_d;
    logic [SW-1:0] sum;

    always_comb begin
        sum   = SW'(cnt_q) + SW'(inc_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (sum > MAX) ? {W{1'b1}} : sum[W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the lfsr16 word stream with lock tracking and
// saturating error/word counters. PRBS_BITERR_EN makes err_cnt count bit errors.
module prbs16_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             locked,
    output state_t           state,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      word_cnt
);

    localparam logic [3:0] LOCK_RUN    = 4'(LOCK_CNT);
    localparam logic [8:0] UNLOCK_MISS = 9'(UNLOCK_CNT);

    state_t      state_q;
    logic [15:0] exp_q;
    logic [3:0]  run_q;
    logic [7:0]  miss_q;
    logic        locked_q;
    logic        err_flag_q;

    logic [15:0] data_step;
    logic [15:0] exp_step;
    logic        match;
    logic [3:0]  run_inc;
    logic [8:0]  miss_inc;
    logic        word_en;
    logic        err_en;
    logic [4:0]  err_inc;

    assign data_step = lfsr16_step(in_data);
    assign exp_step  = lfsr16_step(exp_q);
    assign match     = (in_data == exp_q);
    assign run_inc   = run_q + 4'd1;
    assign miss_inc  = {1'b0, miss_q} + 9'd1;

    // Once locked the expectation flywheels from exp_q, never from the data,
    // so isolated bit errors cannot knock the checker off the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            err_flag_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (in_valid && (in_data != 16'h0000)) begin
                        exp_q   <= data_step;
                        run_q   <= 4'd1;
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_valid) begin
                        if (match) begin
                            exp_q <= data_step;
                            run_q <= run_inc;
                            if (run_inc == LOCK_RUN) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end else if (in_data != 16'h0000) begin
                            exp_q <= data_step;
                            run_q <= 4'd1;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid) begin
                        exp_q <= exp_step;
                        if (match) begin
                            miss_q <= '0;
                        end else begin
                            err_flag_q <= 1'b1;
                            miss_q     <= miss_inc[7:0];
                            if (miss_inc == UNLOCK_MISS) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                run_q    <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign word_en = in_valid && (state_q == LOCKED);
    assign err_en  = word_en && !match;

`ifdef PRBS_BITERR_EN
    assign err_inc = popcount16(in_data ^ exp_q);
`else
    assign err_inc = 5'd1;
`endif

    sat_cnt #(
        .W     (ERR_W),
        .INC_W (5)
    ) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .en_i   (err_en),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt)
    );

    sat_cnt #(
        .W     (32),
        .INC_W (1)
    ) u_word_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .en_i   (word_en),
        .inc_i  (1'b1),
        .cnt_o  (word_cnt)
    );

    assign locked   = locked_q;
    assign state    = state_q;
    assign err_flag = err_flag_q;

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
Receive-side counterpart of the lfsr16 generator. It takes the 16-bit word stream from lfsr16 plus a per-word valid, self-synchronises to the sequence, and reports lock status and error counts. It sits between a data source (loopback of the generator output or an external link) and the display/register path, so error counts can be shown on the 7-segment display.

Parameters:
LOCK_CNT, 4, consecutive valid words needed to declare lock; includes the seeding word; legal range 2..15.
UNLOCK_CNT, 3, consecutive mismatching words in LOCKED that force a return to HUNT; legal range 1..255.
ERR_W, 16, width of the saturating error counter.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
clr  in  1  synchronous clear of err_cnt and word_cnt; state is not affected.
in_valid  in  1  in_data is sampled this cycle.
in_data  in  16  received LFSR word.
locked  out  1  high while state is LOCKED.
state  out  2  current state encoding (prbs_pkg::state_t).
err_flag  out  1  one-cycle pulse for each mismatching word accepted in LOCKED.
err_cnt  out  ERR_W  saturating error count.
word_cnt  out  32  saturating count of words accepted in LOCKED.

Behaviour:
- Sequence definition: step(x) = {x[14:0], x[15]^x[13]^x[12]^x[10]}, i.e. x^16+x^14+x^13+x^11+1. Each generator enable advances the sequence exactly one step. 0x0000 is the lock-up word and is never a valid seed.
- Reset (rst_n=0, asynchronous): state=HUNT, exp=0, run=0, miss=0, locked=0, err_flag=0, err_cnt=0, word_cnt=0.
- Latency: every output is registered and reflects the in_valid sample one clk later. Cycles with in_valid=0 change nothing except clr handling and err_flag returning low.
- HUNT (2'd0):
  - valid with in_data!=0: exp<=step(in_data), run<=1, go to VERIFY.
  - valid with in_data==0: stay in HUNT.
- VERIFY (2'd1), on valid:
  - in_data==exp: exp<=step(in_data), run<=run+1. If run+1==LOCK_CNT, go to LOCKED with miss<=0.
  - Mismatch with in_data!=0: reseed (exp<=step(in_data), run<=1) and stay in VERIFY.
  - Mismatch with in_data==0: go to HUNT.
  - No error counting in this state.
- LOCKED (2'd2), on valid:
  - word_cnt increments, saturating at 0xFFFF_FFFF.
  - Match: exp<=step(exp), miss<=0.
  - Mismatch: flywheel (exp<=step(exp), no reseed), err_flag=1 for one cycle, err_cnt increments (saturating at 2^ERR_W-1), miss<=miss+1. If miss+1==UNLOCK_CNT, go to HUNT with run<=0; err_cnt keeps its value.
- Encoding 2'd3 is unreachable; if it is ever entered, go to HUNT on the next clk.
- clr together with valid in the same cycle: the counters clear (clr wins over increment), and the state machine processes the word normally. err_flag is not affected by clr.
- A deassert of rst_n mid-stream takes effect on the next clk edge; re-lock needs LOCK_CNT fresh valid words.

Optional Feature:
PRBS_BITERR_EN
- Defined: a mismatch in LOCKED adds popcount(in_data ^ exp) (1..16) to err_cnt, saturating; the counter clamps at max rather than wrapping.
- Not defined: err_cnt counts mismatching words, +1 per mismatch.
- Lock and unlock logic is identical in both builds.

Decomposition:
- Package prbs_pkg holds:
  - state_t enum {HUNT, VERIFY, LOCKED}, 2 bits.
  - localparam POLY_TAPS = 16'hB400.
  - function lfsr16_step(x), which lfsr16 shares so generator and checker cannot diverge.
  - function popcount16.
- One sub-module: sat_cnt #(W), a saturating accumulator with clr, en and an increment input. It is instantiated for err_cnt and word_cnt.

Test Plan:
1. Seed 0x1ACE, drive 6 consecutive lfsr16 words with in_valid gaps -> state goes HUNT->VERIFY after word 1; locked rises 1 clk after word 4; word_cnt=2 after word 6; err_cnt=0.
2. While locked, flip bit 0 of one word -> err_flag pulses once, err_cnt=1, locked stays 1; the next uncorrupted word matches (flywheel check).
3. While locked, corrupt 3 consecutive words -> locked falls 1 clk after the 3rd, state=HUNT, err_cnt=3; 4 further clean words relock.
4. Drive 0x0000 repeatedly from reset -> state stays HUNT. Then drive 0x1ACE, 0x1234 -> VERIFY reseeds on 0x1234 with run=1.
5. ERR_W=4, UNLOCK_CNT=255, 20 single-word errors interleaved with good words -> err_cnt saturates at 15. Then pulse clr coincident with a further error -> err_cnt=0.
6. rst_n low for 1 clk while locked with counts nonzero -> locked, err_cnt and word_cnt read 0 immediately (asynchronous). With PRBS_BITERR_EN defined, a single word with 3 flipped bits -> err_cnt=3.
